sine_scheduler: RTL



---
 rtl/sine_scheduler_if.sv | 40 ++++
 rtl/sine_scheduler.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sine_scheduler_if.sv
// sine_scheduler_if: bus between the DDS sequencer and the logic around it.
// It carries the config write port, the sample tick, the shared sine_table
// lookup (tab_id out, tab_data back) and the tagged sample output beat.
//   master : config bus / timer / sine_table side (drives cfg_*, tick, tab_data)
//   slave  : sine_scheduler side (drives busy, tab_id, out_*, overrun)
// Macro SINE_SCHED_COS_EN adds out_cos (quarter-turn offset sample).
interface sine_scheduler_if #(
    parameter int NUM_CH    = 4,
    parameter int ROM_DEPTH = 64,
    parameter int ROM_WIDTH = 8,
    parameter int ACCW      = 16,
    parameter int ADDRW     = $clog2(4*ROM_DEPTH),
    parameter int CHW       = $clog2(NUM_CH)
);
    logic                   cfg_we;
    logic [CHW-1:0]         cfg_ch;
    logic [ACCW-1:0]        cfg_inc;
    logic                   cfg_en;
    logic                   tick;
    logic                   busy;
    logic [ADDRW-1:0]       tab_id;
    logic [2*ROM_WIDTH-1:0] tab_data;
    logic                   out_valid;
    logic [CHW-1:0]         out_ch;
    logic [2*ROM_WIDTH-1:0] out_data;
    logic                   overrun;
`ifdef SINE_SCHED_COS_EN
    logic [2*ROM_WIDTH-1:0] out_cos;

    modport master (output cfg_we, cfg_ch, cfg_inc, cfg_en, tick, tab_data,
                    input  busy, tab_id, out_valid, out_ch, out_data, out_cos, overrun);
    modport slave  (input  cfg_we, cfg_ch, cfg_inc, cfg_en, tick, tab_data,
                    output busy, tab_id, out_valid, out_ch, out_data, out_cos, overrun);
`else
    modport master (output cfg_we, cfg_ch, cfg_inc, cfg_en, tick, tab_data,
                    input  busy, tab_id, out_valid, out_ch, out_data, overrun);
    modport slave  (input  cfg_we, cfg_ch, cfg_inc, cfg_en, tick, tab_data,
                    output busy, tab_id, out_valid, out_ch, out_data, overrun);
`endif
endinterface

// File: rtl/sine_scheduler.sv
// sine_scheduler: time-multiplexed DDS sequencer. One combinational
// sine_table is shared by NUM_CH phase accumulators; each tick sweeps the
// channels in order, looks up every enabled channel and emits one tagged
// sample beat per enabled channel.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sine_scheduler_if.slave (config write, tick, busy, table
//              address/data, out_valid/out_ch/out_data, overrun)
// Optional macro SINE_SCHED_COS_EN: each enabled channel also does a second
// lookup a quarter turn ahead, returned on out_cos alongside out_data.
module sine_scheduler #(
    parameter int NUM_CH    = 4,
    parameter int ROM_DEPTH = 64,
    parameter int ROM_WIDTH = 8,
    parameter int ADDRW     = $clog2(4*ROM_DEPTH),
    parameter int ACCW      = 16,
    parameter int CHW       = $clog2(NUM_CH)
) (
    input logic            clk,
    input logic            rst,
    sine_scheduler_if.slave bus
);
`ifdef SINE_SCHED_COS_EN
    typedef enum logic [2:0] {IDLE, ADDR, DATA, ADDR2, DATA2} state_t;
    localparam logic [ACCW-1:0] QTR = ACCW'(1) << (ACCW-2);
`else
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
`endif

    state_t                          r_state;
    logic [CHW-1:0]                  r_ch;
    logic [NUM_CH-1:0][ACCW-1:0]     r_acc;
    logic [NUM_CH-1:0][ACCW-1:0]     r_inc;
    logic [NUM_CH-1:0]               r_en;
    logic [ADDRW-1:0]                r_tab_id;
    logic                            r_out_valid;
    logic [CHW-1:0]                  r_out_ch;
    logic [2*ROM_WIDTH-1:0]          r_out_data;
    logic                            r_overrun;
`ifdef SINE_SCHED_COS_EN
    logic [2*ROM_WIDTH-1:0]          r_hold;
    logic [2*ROM_WIDTH-1:0]          r_out_cos;
    logic [ACCW-1:0]                 w_cos_acc;
    assign w_cos_acc = r_acc[r_ch] + QTR;
`endif

    logic w_last;
    logic w_cfg_ok;
    assign w_last = (r_ch == CHW'(NUM_CH-1));

    // With a power-of-two channel count every cfg_ch value is a real channel.
    if ((1 << CHW) == NUM_CH) begin : g_cfg_all
        assign w_cfg_ok = 1'b1;
    end else begin : g_cfg_rng
        assign w_cfg_ok = ({1'b0, bus.cfg_ch} < (CHW+1)'(NUM_CH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ch        <= '0;
            r_acc       <= '0;
            r_inc       <= '0;
            r_en        <= '0;
            r_tab_id    <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_data  <= '0;
            r_overrun   <= 1'b0;
`ifdef SINE_SCHED_COS_EN
            r_hold      <= '0;
            r_out_cos   <= '0;
`endif
        end else begin
            r_out_valid <= 1'b0;
            // A tick during any busy cycle is dropped, never queued.
            r_overrun   <= bus.tick && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (bus.tick) begin
                        r_state <= ADDR;
                        r_ch    <= '0;
                    end
                end
                ADDR: begin
                    if (r_en[r_ch]) begin
                        r_tab_id <= r_acc[r_ch][ACCW-1 -: ADDRW];
                        r_state  <= DATA;
                    end else if (w_last) begin
                        r_state <= IDLE;
                    end else begin
                        r_ch <= r_ch + CHW'(1);
                    end
                end
`ifdef SINE_SCHED_COS_EN
                DATA: begin
                    r_hold  <= bus.tab_data;
                    r_state <= ADDR2;
                end
                ADDR2: begin
                    r_tab_id <= w_cos_acc[ACCW-1 -: ADDRW];
                    r_state  <= DATA2;
                end
                DATA2: begin
                    r_out_data  <= r_hold;
                    r_out_cos   <= bus.tab_data;
                    r_out_ch    <= r_ch;
                    r_out_valid <= 1'b1;
                    r_acc[r_ch] <= r_acc[r_ch] + r_inc[r_ch];
                    if (w_last) begin
                        r_state <= IDLE;
                    end else begin
                        r_ch    <= r_ch + CHW'(1);
                        r_state <= ADDR;
                    end
                end
`else
                DATA: begin
                    r_out_data  <= bus.tab_data;
                    r_out_ch    <= r_ch;
                    r_out_valid <= 1'b1;
                    r_acc[r_ch] <= r_acc[r_ch] + r_inc[r_ch];
                    if (w_last) begin
                        r_state <= IDLE;
                    end else begin
                        r_ch    <= r_ch + CHW'(1);
                        r_state <= ADDR;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
            // Config write comes last so a phase clear overrides the
            // accumulate of the same cycle; the accumulate already read the
            // old inc.
            if (bus.cfg_we && w_cfg_ok) begin
                r_inc[bus.cfg_ch] <= bus.cfg_inc;
                r_en[bus.cfg_ch]  <= bus.cfg_en;
                if (!bus.cfg_en) begin
                    r_acc[bus.cfg_ch] <= '0;
                end
            end
        end
    end

    assign bus.busy      = (r_state != IDLE);
    assign bus.tab_id    = r_tab_id;
    assign bus.out_valid = r_out_valid;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_data  = r_out_data;
    assign bus.overrun   = r_overrun;
`ifdef SINE_SCHED_COS_EN
    assign bus.out_cos   = r_out_cos;
`endif
endmodule
